// File: rtl/rope_game_pkg.sv
// Shared types and constants for the tug-of-war engine: FSM state encoding,
// rope/score widths, button lane indices and a saturating score increment.
package rope_game_pkg;

  localparam int ROPE_W  = 10;
  localparam int SCORE_W = 4;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd15;

  localparam int N_BTN     = 3;
  localparam int BTN_START = 0;
  localparam int BTN_L     = 1;
  localparam int BTN_R     = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    WIN_L     = 3'd3,
    WIN_R     = 3'd4
  } state_e;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/rope_game_ctrl_if.sv
// Player/frame inputs and renderer/scoreboard outputs of the game engine.
// master drives the buttons and frame tick; slave is the engine.
interface rope_game_ctrl_if;
  import rope_game_pkg::*;

  logic               i_start;
  logic               i_pull_l;
  logic               i_pull_r;
  logic               i_frame;
  logic [ROPE_W-1:0]  o_rope_loc;
  state_e             o_state;
  logic [1:0]         o_countdown;
  logic [SCORE_W-1:0] o_score_l;
  logic [SCORE_W-1:0] o_score_r;

  modport master (
    output i_start, i_pull_l, i_pull_r, i_frame,
    input  o_rope_loc, o_state, o_countdown, o_score_l, o_score_r
  );

  modport slave (
    input  i_start, i_pull_l, i_pull_r, i_frame,
    output o_rope_loc, o_state, o_countdown, o_score_l, o_score_r
  );

endinterface

// File: rtl/rope_edge_det.sv
// One-bit rising-edge detector. The history flop resets low, so a level that is
// already high when reset releases is reported as a fresh press.
module rope_edge_det (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) prev_q <= 1'b0;
    else       prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/rope_game_ctrl.sv
// Tug-of-war game engine: countdown, play and win phases paced by the frame tick.
// Optional `ROPE_DRIFT_EN: idle rope creeps 1 px toward centre every DRIFT_FRAMES ticks.
module rope_game_ctrl
  import rope_game_pkg::*;
#(
  parameter int CENTER       = 320,
  parameter int STEP         = 8,
  parameter int WIN_MARGIN   = 200,
  parameter int COUNT_FRAMES = 60,
  parameter int DRIFT_FRAMES = 30
) (
  input  logic clk,
  input  logic rstn,
  rope_game_ctrl_if.slave bus
);

  localparam logic signed [ROPE_W:0] LO_S   = (ROPE_W+1)'(CENTER - WIN_MARGIN);
  localparam logic signed [ROPE_W:0] HI_S   = (ROPE_W+1)'(CENTER + WIN_MARGIN);
  localparam logic signed [ROPE_W:0] STEP_S = (ROPE_W+1)'(STEP);
  localparam logic [ROPE_W-1:0]      CTR    = ROPE_W'(CENTER);

  localparam int CF_W = $clog2(COUNT_FRAMES > 1 ? COUNT_FRAMES : 2);
  localparam logic [CF_W-1:0] CF_LAST = CF_W'(COUNT_FRAMES - 1);

  // Button edges: one detector lane per input
  logic [N_BTN-1:0] btn, rise;
  assign btn = {bus.i_pull_r, bus.i_pull_l, bus.i_start};

  genvar g;
  generate
    for (g = 0; g < N_BTN; g++) begin : g_edge
      rope_edge_det u_det (
        .clk    (clk),
        .rstn   (rstn),
        .d_i    (btn[g]),
        .rise_o (rise[g])
      );
    end
  endgenerate

  state_e             state_q;
  logic [ROPE_W-1:0]  rope_q;
  logic [1:0]         cd_q;
  logic [CF_W-1:0]    frame_q;
  logic [SCORE_W-1:0] score_l_q, score_r_q;

`ifdef ROPE_DRIFT_EN
  localparam int DF_W = $clog2(DRIFT_FRAMES > 1 ? DRIFT_FRAMES : 2);
  localparam logic [DF_W-1:0] DF_LAST = DF_W'(DRIFT_FRAMES - 1);
  logic [DF_W-1:0] drift_q;
`endif

  // Next rope position in PLAY; clamped in 11-bit signed before truncation
  logic signed [ROPE_W:0] move_s, sum_s;
  logic [ROPE_W-1:0]      rope_d;
  logic                   press_any;

  always_comb begin
    move_s = '0;
    if (rise[BTN_L] && !rise[BTN_R])      move_s = -STEP_S;
    else if (rise[BTN_R] && !rise[BTN_L]) move_s = STEP_S;
    sum_s = $signed({1'b0, rope_q}) + move_s;
    if (sum_s < LO_S)      sum_s = LO_S;
    else if (sum_s > HI_S) sum_s = HI_S;
    rope_d    = sum_s[ROPE_W-1:0];
    press_any = rise[BTN_L] | rise[BTN_R];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      rope_q    <= CTR;
      cd_q      <= 2'd0;
      frame_q   <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
`ifdef ROPE_DRIFT_EN
      drift_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, WIN_L, WIN_R: begin
          if (rise[BTN_START]) begin
            state_q <= COUNTDOWN;
            rope_q  <= CTR;
            frame_q <= '0;
            cd_q    <= 2'd3;
          end
        end

        COUNTDOWN: begin
          if (bus.i_frame) begin
            if (frame_q == CF_LAST) begin
              frame_q <= '0;
              if (cd_q == 2'd1) begin
                state_q <= PLAY;
                cd_q    <= 2'd0;
`ifdef ROPE_DRIFT_EN
                drift_q <= '0;
`endif
              end else begin
                cd_q <= cd_q - 2'd1;
              end
            end else begin
              frame_q <= frame_q + CF_W'(1);
            end
          end
        end

        PLAY: begin
          rope_q <= rope_d;
          if (sum_s <= LO_S) begin
            state_q   <= WIN_L;
            score_l_q <= sat_inc(score_l_q);
          end else if (sum_s >= HI_S) begin
            state_q   <= WIN_R;
            score_r_q <= sat_inc(score_r_q);
          end
`ifdef ROPE_DRIFT_EN
          // Only reached without a press, so rope_d == rope_q and drift can't win
          if (press_any) begin
            drift_q <= '0;
          end else if (bus.i_frame) begin
            if (drift_q == DF_LAST) begin
              drift_q <= '0;
              if (rope_q > CTR)      rope_q <= rope_q - ROPE_W'(1);
              else if (rope_q < CTR) rope_q <= rope_q + ROPE_W'(1);
            end else begin
              drift_q <= drift_q + DF_W'(1);
            end
          end
`endif
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_rope_loc  = rope_q;
  assign bus.o_state     = state_q;
  assign bus.o_countdown = cd_q;
  assign bus.o_score_l   = score_l_q;
  assign bus.o_score_r   = score_r_q;

endmodule

// File: tb/tb_rope_game_ctrl.sv
// Bench for rope_game_ctrl: game-rule model checked every cycle, directed
// scenarios with literal expectations, then randomized play with random resets.
module tb_rope_game_ctrl;
  import rope_game_pkg::*;

  localparam int C  = 320;
  localparam int ST = 8;
  localparam int M  = 24;
  localparam int CF = 2;
  localparam int DF = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  rope_game_ctrl_if bus();

  rope_game_ctrl #(
    .CENTER(C), .STEP(ST), .WIN_MARGIN(M), .COUNT_FRAMES(CF), .DRIFT_FRAMES(DF)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: plain integers, countdown derived from ticks since entry
  state_e m_state;
  int m_rope, m_cd, m_ticks, m_sl, m_sr, m_idle;
  bit m_ps, m_pl, m_pr;

  task model_reset();
    m_state = IDLE; m_rope = C; m_cd = 0; m_ticks = 0;
    m_sl = 0; m_sr = 0; m_idle = 0;
    m_ps = 0; m_pl = 0; m_pr = 0;
  endtask

  task model_step(input bit s, input bit l, input bit r, input bit f);
    bit es, el, er;
    int nr;
    if (!rstn) return;
    es = s && !m_ps; el = l && !m_pl; er = r && !m_pr;
    m_ps = s; m_pl = l; m_pr = r;
    case (m_state)
      IDLE, WIN_L, WIN_R:
        if (es) begin m_state = COUNTDOWN; m_rope = C; m_ticks = 0; m_cd = 3; end
      COUNTDOWN:
        if (f) begin
          m_ticks++;
          if (m_ticks == 3*CF) begin m_state = PLAY; m_cd = 0; m_idle = 0; end
          else m_cd = 3 - m_ticks / CF;
        end
      PLAY: begin
        nr = m_rope;
        if (el && !er) nr = m_rope - ST;
        if (er && !el) nr = m_rope + ST;
        if (nr < C - M) nr = C - M;
        if (nr > C + M) nr = C + M;
        m_rope = nr;
        if (nr <= C - M)      begin m_state = WIN_L; if (m_sl < 15) m_sl++; end
        else if (nr >= C + M) begin m_state = WIN_R; if (m_sr < 15) m_sr++; end
`ifdef ROPE_DRIFT_EN
        if (el || er) m_idle = 0;
        else if (f) begin
          m_idle++;
          if (m_idle == DF) begin
            m_idle = 0;
            if (m_rope > C) m_rope--;
            else if (m_rope < C) m_rope++;
          end
        end
`endif
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rope_loc",  bus.o_rope_loc,  m_rope);
      chk("state",     bus.o_state,     int'(m_state));
      chk("countdown", bus.o_countdown, m_cd);
      chk("score_l",   bus.o_score_l,   m_sl);
      chk("score_r",   bus.o_score_r,   m_sr);
    end
  end

  task automatic cyc(input bit s, input bit l, input bit r, input bit f);
    bus.i_start = s; bus.i_pull_l = l; bus.i_pull_r = r; bus.i_frame = f;
    @(posedge clk);
    model_step(s, l, r, f);
    @(negedge clk);
  endtask

  task automatic go_play();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (6) begin cyc(0, 0, 0, 1); cyc(0, 0, 0, 0); end
  endtask

  task automatic press(input bit left);
    cyc(0, left, !left, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic async_reset();
    #2 rstn = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  int exp_cd[6] = '{3, 3, 2, 2, 1, 1};

  initial begin
    rstn = 1'b0;
    bus.i_start = 0; bus.i_pull_l = 0; bus.i_pull_r = 0; bus.i_frame = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    cmp_en = 1'b1;

    chk("rst_state", bus.o_state, int'(IDLE));
    chk("rst_rope", bus.o_rope_loc, 320);
    chk("rst_cd", bus.o_countdown, 0);

    // Countdown sequence
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("cd_entry_state", bus.o_state, int'(COUNTDOWN));
    for (int k = 0; k < 6; k++) begin
      chk("cd_seq", bus.o_countdown, exp_cd[k]);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
    end
    chk("play_state", bus.o_state, int'(PLAY));
    chk("play_cd", bus.o_countdown, 0);
    chk("play_rope", bus.o_rope_loc, 320);

    // Simultaneous presses cancel; held press steps once
    cyc(0, 1, 1, 0);
    chk("both_rope", bus.o_rope_loc, 320);
    cyc(0, 0, 0, 0);
    repeat (10) cyc(0, 1, 0, 0);
    chk("held_rope", bus.o_rope_loc, 312);
    cyc(0, 0, 0, 0);
    press(0);
    chk("right_rope", bus.o_rope_loc, 320);

    // Three left presses win the round
    cyc(0, 1, 0, 0); chk("l1", bus.o_rope_loc, 312); cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); chk("l2", bus.o_rope_loc, 304); cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); chk("l3", bus.o_rope_loc, 296);
    chk("win_l_state", bus.o_state, int'(WIN_L));
    chk("win_l_score", bus.o_score_l, 1);
    cyc(0, 0, 0, 0);
    press(1); press(0);
    chk("frozen_rope", bus.o_rope_loc, 296);
    chk("frozen_state", bus.o_state, int'(WIN_L));

    // Right score saturation
    for (int k = 1; k <= 16; k++) begin
      go_play();
      repeat (3) press(0);
      chk("sat_score_r", bus.o_score_r, (k < 15) ? k : 15);
    end
    chk("sat_state", bus.o_state, int'(WIN_R));

    // Asynchronous reset mid-round
    go_play();
    press(1); press(1);
    chk("pre_rst_rope", bus.o_rope_loc, 304);
    async_reset();
    chk("mid_rst_state", bus.o_state, int'(IDLE));
    chk("mid_rst_rope", bus.o_rope_loc, 320);
    chk("mid_rst_sl", bus.o_score_l, 0);
    chk("mid_rst_sr", bus.o_score_r, 0);
    rstn = 1'b1;
    cyc(0, 0, 0, 0);

    // Drift toward centre (only with the macro)
    go_play();
    press(0); press(0);
    chk("drift_start", bus.o_rope_loc, 336);
    repeat (4) begin cyc(0, 0, 0, 1); cyc(0, 0, 0, 0); end
`ifdef ROPE_DRIFT_EN
    chk("drift_4", bus.o_rope_loc, 335);
`else
    chk("drift_4", bus.o_rope_loc, 336);
`endif
    repeat (4) begin cyc(0, 0, 0, 1); cyc(0, 0, 0, 0); end
`ifdef ROPE_DRIFT_EN
    chk("drift_8", bus.o_rope_loc, 334);
`else
    chk("drift_8", bus.o_rope_loc, 336);
`endif

    // Randomized play with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
        rstn = 1'b1;
      end
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
